// File: rtl/t5_sysctl.sv
// t5 system controller: clock pass-through, stretched core reset with software
// request, multi-channel stall merge and stall-timeout abort with error pulses.
module t5_sysctl #(
  parameter int RSTLEN = 4,
  parameter int NCH    = 2,
  parameter int TMO    = 255
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           sys_ena,
  input  logic           swr,
  input  logic [NCH-1:0] xstb,
  input  logic [NCH-1:0] xack,
  output logic           sclk,
  output logic           srst,
  output logic           sena,
  output logic [NCH-1:0] xerr
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  logic [RSTLEN-1:0] rst_q, rst_d;
  logic              ena_q, ena_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NCH-1:0]    stall;
  logic              any;
  logic              hit;
  logic              run;

  assign sclk = sys_clk;
  assign srst = rst_q[RSTLEN-1];

  always_comb begin
    stall = xstb & ~xack;
    any   = |stall;
    run   = sys_ena & ena_q;
    hit   = (TMO != 0) && (cnt_q == TMO_C) && any;
    sena  = run & (~any | hit);
    xerr  = (hit & run) ? stall : '0;
  end

  always_comb begin
    rst_d = swr ? '1 : {rst_q[RSTLEN-2:0], 1'b0};
    ena_d = ~srst;
    cnt_d = cnt_q;
    // Priority: reset, freeze on sys_ena low, clear on completion/abort, count.
    if (srst || swr) begin
      cnt_d = '0;
    end else if (!sys_ena) begin
      cnt_d = cnt_q;
    end else if (sena || !any) begin
      cnt_d = '0;
    end else if (ena_q && (cnt_q != TMO_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_q <= '1;
      ena_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      rst_q <= rst_d;
      ena_q <= ena_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
